// File: rtl/midi_msg_decoder.sv
// MIDI channel-voice parser with running status and monophonic last-note-priority gating.
// Drives note number, velocity, gate and program values for the downstream nco.
module midi_msg_decoder #(
    parameter int unsigned CHANNEL = 0,
    parameter bit          OMNI    = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] BYTE_IN,
    input  logic       BYTE_VALID,
    output logic [6:0] NOTE_NUM,
    output logic [6:0] NOTE_VEL,
    output logic [6:0] PROGRAM,
    output logic       GATE,
    output logic       NOTE_STB,
    output logic       PROG_STB
);

    localparam int unsigned DATA_W = 7;
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  WAIT_D1 = 2'd1;
    localparam logic [1:0]  WAIT_D2 = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [7:0]        status_q,   status_d;
    logic [DATA_W-1:0] d1_q,       d1_d;
    logic [DATA_W-1:0] note_num_q, note_num_d;
    logic [DATA_W-1:0] note_vel_q, note_vel_d;
    logic [DATA_W-1:0] program_q,  program_d;
    logic              gate_q,     gate_d;
    logic              note_stb_q, note_stb_d;
    logic              prog_stb_q, prog_stb_d;

    logic              done;
    logic              note_off;
    logic              one_byte;
    logic              chan_ok;
    logic [DATA_W-1:0] msg_d1;
    logic [DATA_W-1:0] msg_d2;

    assign one_byte = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
    assign chan_ok  = OMNI || (status_q[3:0] == 4'(CHANNEL));

    // Byte classification, message assembly and completion actions
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        d1_d       = d1_q;
        note_num_d = note_num_q;
        note_vel_d = note_vel_q;
        program_d  = program_q;
        gate_d     = gate_q;
        note_stb_d = 1'b0;
        prog_stb_d = 1'b0;
        done       = 1'b0;
        note_off   = 1'b0;
        msg_d1     = d1_q;
        msg_d2     = '0;

        // Realtime bytes (0xF8-0xFF) leave everything untouched
        if (BYTE_VALID && (BYTE_IN[7:3] != 5'b11111)) begin
            if (BYTE_IN[7:4] == 4'hF) begin
                state_d  = IDLE;
                status_d = '0;
            end else if (BYTE_IN[7]) begin
                status_d = BYTE_IN;
                state_d  = WAIT_D1;
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        d1_d = BYTE_IN[6:0];
                        if (one_byte) begin
                            done   = 1'b1;
                            msg_d1 = BYTE_IN[6:0];
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        done    = 1'b1;
                        msg_d2  = BYTE_IN[6:0];
                        state_d = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end

        if (done && chan_ok) begin
            case (status_q[7:4])
                4'h9: begin
                    if (msg_d2 != '0) begin
                        note_num_d = msg_d1;
                        note_vel_d = msg_d2;
                        gate_d     = 1'b1;
                        note_stb_d = 1'b1;
                    end else begin
                        note_off = 1'b1;
                    end
                end
                4'h8: note_off = 1'b1;
                4'hC: begin
                    program_d  = msg_d1;
                    prog_stb_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Only the currently held note can be released
        if (note_off && gate_q && (msg_d1 == note_num_q)) begin
            note_vel_d = '0;
            gate_d     = 1'b0;
            note_stb_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            status_q   <= '0;
            d1_q       <= '0;
            note_num_q <= '0;
            note_vel_q <= '0;
            program_q  <= '0;
            gate_q     <= 1'b0;
            note_stb_q <= 1'b0;
            prog_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            d1_q       <= d1_d;
            note_num_q <= note_num_d;
            note_vel_q <= note_vel_d;
            program_q  <= program_d;
            gate_q     <= gate_d;
            note_stb_q <= note_stb_d;
            prog_stb_q <= prog_stb_d;
        end
    end

    assign NOTE_NUM = note_num_q;
    assign NOTE_VEL = note_vel_q;
    assign PROGRAM  = program_q;
    assign GATE     = gate_q;
    assign NOTE_STB = note_stb_q;
    assign PROG_STB = prog_stb_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Bench for midi_msg_decoder: a channel-0 instance and an omni instance share one byte stream,
// checked against a vector table, directed sequences and a message-level reference model.
module tb_midi_msg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;

    logic [6:0] nn0, nv0, pg0, nn1, nv1, pg1;
    logic       g0, ns0, ps0, g1, ns1, ps1;

    always #5 clk = ~clk;

    midi_msg_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
        .NOTE_NUM(nn0), .NOTE_VEL(nv0), .PROGRAM(pg0), .GATE(g0),
        .NOTE_STB(ns0), .PROG_STB(ps0)
    );

    midi_msg_decoder #(.CHANNEL(0), .OMNI(1'b1)) dut_omni (
        .CLK(clk), .RST_N(rst_n), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
        .NOTE_NUM(nn1), .NOTE_VEL(nv1), .PROGRAM(pg1), .GATE(g1),
        .NOTE_STB(ns1), .PROG_STB(ps1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: running status plus a queue of collected data bytes
    int m_rs;
    int m_data[$];
    int m_note[2], m_vel[2], m_prog[2], m_gate[2], m_nstb[2], m_pstb[2];

    typedef struct {
        bit v;
        int b;
        int note;
        int vel;
        int prog;
        int gate;
        int nstb;
        int pstb;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_rs = -1;
        m_data.delete();
        for (int m = 0; m < 2; m++) begin
            m_note[m] = 0; m_vel[m] = 0; m_prog[m] = 0;
            m_gate[m] = 0; m_nstb[m] = 0; m_pstb[m] = 0;
        end
    endfunction

    function automatic void model_msg(int st, int d1, int d2);
        int hi;
        hi = st / 16;
        for (int m = 0; m < 2; m++) begin
            if (m == 1 || (st % 16) == 0) begin
                if (hi == 9 && d2 > 0) begin
                    m_note[m] = d1; m_vel[m] = d2; m_gate[m] = 1; m_nstb[m] = 1;
                end else if (hi == 8 || hi == 9) begin
                    if (m_gate[m] == 1 && d1 == m_note[m]) begin
                        m_vel[m] = 0; m_gate[m] = 0; m_nstb[m] = 1;
                    end
                end else if (hi == 12) begin
                    m_prog[m] = d1; m_pstb[m] = 1;
                end
            end
        end
    endfunction

    function automatic void model_byte(int b);
        int need;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            m_rs = -1;
            m_data.delete();
        end else if (b >= 'h80) begin
            m_rs = b;
            m_data.delete();
        end else if (m_rs >= 0) begin
            m_data.push_back(b);
            need = ((m_rs / 16) == 12 || (m_rs / 16) == 13) ? 1 : 2;
            if (m_data.size() == need) begin
                model_msg(m_rs, m_data[0], (need == 2) ? m_data[1] : 0);
                m_data.delete();
            end
        end
    endfunction

    task automatic check_model();
        check("note0", int'(nn0), m_note[0]);
        check("vel0",  int'(nv0), m_vel[0]);
        check("prog0", int'(pg0), m_prog[0]);
        check("gate0", int'(g0),  m_gate[0]);
        check("nstb0", int'(ns0), m_nstb[0]);
        check("pstb0", int'(ps0), m_pstb[0]);
        check("note1", int'(nn1), m_note[1]);
        check("vel1",  int'(nv1), m_vel[1]);
        check("prog1", int'(pg1), m_prog[1]);
        check("gate1", int'(g1),  m_gate[1]);
        check("nstb1", int'(ns1), m_nstb[1]);
        check("pstb1", int'(ps1), m_pstb[1]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_note0"}, int'(nn0), 0);
        check({tag, "_vel0"},  int'(nv0), 0);
        check({tag, "_prog0"}, int'(pg0), 0);
        check({tag, "_gate0"}, int'(g0),  0);
        check({tag, "_nstb0"}, int'(ns0), 0);
        check({tag, "_pstb0"}, int'(ps0), 0);
        check({tag, "_note1"}, int'(nn1), 0);
        check({tag, "_prog1"}, int'(pg1), 0);
        check({tag, "_gate1"}, int'(g1),  0);
    endtask

    task automatic step(input bit v, input int b);
        byte_valid = v;
        byte_in    = 8'(b);
        for (int m = 0; m < 2; m++) begin
            m_nstb[m] = 0;
            m_pstb[m] = 0;
        end
        if (v) model_byte(b);
        @(posedge clk);
        #1;
        check_model();
    endtask

    function automatic void add(bit v, int b, int note, int vel, int prog, int gate, int nstb, int pstb);
        vec_t e;
        e = '{v, b, note, vel, prog, gate, nstb, pstb};
        tbl.push_back(e);
    endfunction

    int his[8] = '{8, 9, 9, 12, 10, 11, 13, 14};

    initial begin
        int r, b;
        bit v;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        model_reset();

        #12;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   v  byte   note vel prog gate nstb pstb   (channel-0 instance)
        add(1, 'h90,   0,   0,  0,   0,   0,   0);
        add(1, 'h32,   0,   0,  0,   0,   0,   0);
        add(1, 'h7F,  50, 127,  0,   1,   1,   0);
        add(0, 'h00,  50, 127,  0,   1,   0,   0);
        add(1, 'h40,  50, 127,  0,   1,   0,   0);
        add(1, 'h14,  64,  20,  0,   1,   1,   0);
        add(1, 'h32,  64,  20,  0,   1,   0,   0);
        add(1, 'h00,  64,  20,  0,   1,   0,   0);
        add(1, 'h40,  64,  20,  0,   1,   0,   0);
        add(1, 'h00,  64,   0,  0,   0,   1,   0);
        add(1, 'hC0,  64,   0,  0,   0,   0,   0);
        add(1, 'h01,  64,   0,  1,   0,   0,   1);
        add(1, 'h05,  64,   0,  5,   0,   0,   1);
        add(0, 'h00,  64,   0,  5,   0,   0,   0);
        add(1, 'h90,  64,   0,  5,   0,   0,   0);
        add(1, 'hF8,  64,   0,  5,   0,   0,   0);
        add(1, 'h32,  64,   0,  5,   0,   0,   0);
        add(1, 'hFE,  64,   0,  5,   0,   0,   0);
        add(1, 'h7F,  50, 127,  5,   1,   1,   0);
        add(1, 'hF0,  50, 127,  5,   1,   0,   0);
        add(1, 'h10,  50, 127,  5,   1,   0,   0);
        add(1, 'h20,  50, 127,  5,   1,   0,   0);
        add(1, 'h33,  50, 127,  5,   1,   0,   0);
        add(1, 'h44,  50, 127,  5,   1,   0,   0);
        add(1, 'h91,  50, 127,  5,   1,   0,   0);
        add(1, 'h32,  50, 127,  5,   1,   0,   0);
        add(1, 'h7F,  50, 127,  5,   1,   0,   0);
        add(1, 'h90,  50, 127,  5,   1,   0,   0);
        add(1, 'h32,  50, 127,  5,   1,   0,   0);
        add(1, 'hC0,  50, 127,  5,   1,   0,   0);
        add(1, 'h07,  50, 127,  7,   1,   0,   1);
        add(0, 'h00,  50, 127,  7,   1,   0,   0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].b);
            check("tbl_note", int'(nn0), tbl[i].note);
            check("tbl_vel",  int'(nv0), tbl[i].vel);
            check("tbl_prog", int'(pg0), tbl[i].prog);
            check("tbl_gate", int'(g0),  tbl[i].gate);
            check("tbl_nstb", int'(ns0), tbl[i].nstb);
            check("tbl_pstb", int'(ps0), tbl[i].pstb);
        end

        // Omni instance saw the channel-1 Note On from the table
        check("omni_note", int'(nn1), 50);
        check("omni_vel",  int'(nv1), 127);

        // Asynchronous reset between status and first data byte of a Note On
        step(1, 'h90);
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        #2;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 'h32);
        step(1, 'h7F);
        step(0, 'h00);
        check("post_rst_note", int'(nn0), 0);
        check("post_rst_gate", int'(g0),  0);

        // Randomized byte stream against the reference model
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       b = 'hF8 + int'($urandom_range(0, 7));
            else if (r < 12) b = 'hF0 + int'($urandom_range(0, 7));
            else if (r < 32) b = his[$urandom_range(0, 7)] * 16 + int'($urandom_range(0, 1));
            else if (r < 65) b = 60 + int'($urandom_range(0, 3));
            else if (r < 78) b = 0;
            else             b = int'($urandom_range(0, 127));
            v = ($urandom_range(0, 9) < 8);
            step(v, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
